// File: rtl/vjtag_mem_bridge_if.sv
// Virtual-JTAG hub strobes plus the single SRAM port, bundled for vjtag_mem_bridge.
// master = hub/memory environment, slave = the bridge.
interface vjtag_mem_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [1:0]        ir_in;
  logic              v_cdr;
  logic              v_sdr;
  logic              v_udr;
  logic              tdi;
  logic              tdo;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output ir_in, v_cdr, v_sdr, v_udr, tdi, mem_rdata,
    input  tdo, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  ir_in, v_cdr, v_sdr, v_udr, tdi, mem_rdata,
    output tdo, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/vjtag_mem_bridge.sv
// Virtual-JTAG DR scans to single-cycle SRAM writes and prefetched reads, tck domain only.
// Define VJTAG_MEM_AUTOINC_EN to advance the address after every WRITE/READ update.
module vjtag_mem_bridge #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input logic               tck,
  input logic               aclr,
  vjtag_mem_bridge_if.slave bus
);

  localparam int AD_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int SR_W   = (AD_MAX > 8) ? AD_MAX : 8;
  localparam logic [1:0] IR_STATUS = 2'd0;
  localparam logic [1:0] IR_ADDR   = 2'd1;
  localparam logic [1:0] IR_WRITE  = 2'd2;
  localparam logic [1:0] IR_READ   = 2'd3;
  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

`ifdef VJTAG_MEM_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WR, INC, PREFETCH, WAIT} state_t;

  state_t            state, state_nx;
  logic [SR_W-1:0]   sr, sr_shift, sr_cap;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wreg, rbuf;
  logic              overrun, stale;
  logic [1:0]        wcnt;
  logic              busy, wait_done;
  int                len;

  assign busy      = (state != IDLE);
  assign wait_done = (state == WAIT) && (wcnt == WAIT_LAST);

  // Active DR length follows the current instruction.
  always_comb begin
    len = 8;
    case (bus.ir_in)
      IR_ADDR:  len = ADDR_W;
      IR_WRITE,
      IR_READ:  len = DATA_W;
      default:  len = 8;
    endcase
  end

  // tdi enters at bit L-1; everything at L and above stays zero.
  always_comb begin
    sr_shift = {1'b0, sr[SR_W-1:1]};
    for (int i = 0; i < SR_W; i++) begin
      if (i == len - 1)  sr_shift[i] = bus.tdi;
      else if (i >= len) sr_shift[i] = 1'b0;
    end
  end

  always_comb begin
    sr_cap = '0;
    case (bus.ir_in)
      IR_STATUS: sr_cap[2:0]        = {stale, overrun, busy};
      IR_ADDR:   sr_cap[ADDR_W-1:0] = addr;
      IR_READ:   sr_cap[DATA_W-1:0] = rbuf;
      default:   sr_cap             = '0;
    endcase
  end

  always_ff @(posedge tck or posedge aclr) begin
    if (aclr)           sr <= '0;
    else if (bus.v_udr) sr <= sr;
    else if (bus.v_cdr) sr <= sr_cap;
    else if (bus.v_sdr) sr <= sr_shift;
  end

  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (bus.v_udr) begin
          case (bus.ir_in)
            IR_ADDR:  state_nx = PREFETCH;
            IR_WRITE: state_nx = WR;
            IR_READ:  state_nx = INC;
            default:  state_nx = IDLE;
          endcase
        end
      WR:       state_nx = INC;
      INC:      state_nx = PREFETCH;
      PREFETCH: state_nx = WAIT;
      WAIT:     if (wait_done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      addr    <= '0;
      wreg    <= '0;
      rbuf    <= '0;
      overrun <= 1'b0;
      stale   <= 1'b0;
      wcnt    <= '0;
    end else begin
      // STATUS update always clears; any other update while busy is dropped and flagged.
      if (bus.v_udr) begin
        if (bus.ir_in == IR_STATUS) begin
          overrun <= 1'b0;
          stale   <= 1'b0;
        end else if (busy)                overrun <= 1'b1;
        else if (bus.ir_in == IR_ADDR)    addr    <= sr[ADDR_W-1:0];
        else if (bus.ir_in == IR_WRITE)   wreg    <= sr[DATA_W-1:0];
      end else if (bus.v_cdr && bus.ir_in == IR_READ && busy) begin
        stale <= 1'b1;
      end
      if (state == INC && AUTOINC) addr <= addr + 1'b1;
      wcnt <= (state == WAIT) ? wcnt + 2'd1 : 2'd0;
      if (wait_done) rbuf <= bus.mem_rdata;
    end
  end

  assign bus.tdo       = sr[0];
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wreg;
  assign bus.mem_we    = (state == WR);
  assign bus.mem_re    = (state == PREFETCH);

endmodule

// File: tb/tb_vjtag_mem_bridge.sv
// Directed + randomized scans against a transaction-level model of the bridge and memory.
module tb_vjtag_mem_bridge;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RL = 2;
`ifdef VJTAG_MEM_AUTOINC_EN
  localparam logic [15:0] STEP = 16'd1;
`else
  localparam logic [15:0] STEP = 16'd0;
`endif

  logic tck = 1'b0;
  logic aclr;
  always #5 tck = ~tck;

  vjtag_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  vjtag_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)) dut (
    .tck(tck), .aclr(aclr), .bus(bus)
  );

  // Environment SRAM with RL-cycle read pipe; garbage when no read is in flight.
  bit   [7:0]  sram [0:65535];
  logic [7:0]  rpipe [1:RL];
  logic [23:0] wlog [$];
  logic [15:0] last_re_addr;

  always @(posedge tck) begin
    if (bus.mem_we) begin
      sram[bus.mem_addr] <= bus.mem_wdata;
      wlog.push_back({bus.mem_addr, bus.mem_wdata});
    end
    rpipe[1] <= bus.mem_re ? sram[bus.mem_addr] : 8'($urandom);
    for (int k = 2; k <= RL; k++) rpipe[k] <= rpipe[k-1];
    if (bus.mem_re) last_re_addr <= bus.mem_addr;
  end
  assign bus.mem_rdata = rpipe[RL];

  // Reference model: memory contents, address pointer, read buffer, sticky flags.
  bit   [7:0]  mm [0:65535];
  logic [15:0] a_m;
  logic [7:0]  rbuf_m;
  logic        ovr_m, stl_m;
  int          vec, bad;
  logic [15:0] o;
  int          n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dr_scan(input logic [1:0] ir, input logic [15:0] din, input int len,
                         output logic [15:0] dout);
    bus.ir_in = ir;
    bus.v_cdr = 1'b1;
    @(negedge tck);
    bus.v_cdr = 1'b0;
    bus.v_sdr = 1'b1;
    dout = '0;
    for (int i = 0; i < len; i++) begin
      bus.tdi = din[i];
      dout[i] = bus.tdo;
      @(negedge tck);
    end
    bus.v_sdr = 1'b0;
    bus.v_udr = 1'b1;
    @(negedge tck);
    bus.v_udr = 1'b0;
  endtask

  task automatic settle();
    repeat (RL + 6) @(negedge tck);
  endtask

  task automatic op_addr(input logic [15:0] a);
    logic [15:0] d;
    dr_scan(2'd1, a, AW, d);
    chk("addr_capture", d, a_m);
    a_m = a;
    rbuf_m = mm[a_m];
    settle();
    chk("addr_prefetch", last_re_addr, a_m);
  endtask

  task automatic op_write(input logic [7:0] d);
    logic [15:0] q;
    int cnt;
    dr_scan(2'd2, {8'h00, d}, DW, q);
    chk("write_capture", q[7:0], 8'h00);
    cnt = wlog.size();
    settle();
    chk("write_count", wlog.size(), cnt + 1);
    chk("write_entry", wlog[$], {a_m, d});
    mm[a_m] = d;
    a_m = a_m + STEP;
    rbuf_m = mm[a_m];
    chk("write_prefetch", last_re_addr, a_m);
  endtask

  task automatic op_read();
    logic [15:0] q;
    dr_scan(2'd3, 16'($urandom), DW, q);
    chk("read_data", q[7:0], rbuf_m);
    a_m = a_m + STEP;
    rbuf_m = mm[a_m];
    settle();
    chk("read_prefetch", last_re_addr, a_m);
  endtask

  task automatic op_status();
    logic [15:0] q;
    dr_scan(2'd0, 16'($urandom), 8, q);
    chk("status", q[7:0], {5'b0, stl_m, ovr_m, 1'b0});
    stl_m = 1'b0;
    ovr_m = 1'b0;
    settle();
  endtask

  initial begin
    vec = 0; bad = 0;
    a_m = '0; rbuf_m = '0; ovr_m = 1'b0; stl_m = 1'b0;
    bus.ir_in = 2'd0; bus.v_cdr = 1'b0; bus.v_sdr = 1'b0; bus.v_udr = 1'b0; bus.tdi = 1'b0;
    aclr = 1'b1;
    #1;
    chk("rst_tdo", bus.tdo, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_re", bus.mem_re, 1'b0);
    chk("rst_addr", bus.mem_addr, 16'h0);
    chk("rst_wdata", bus.mem_wdata, 8'h0);
    repeat (3) @(negedge tck);
    aclr = 1'b0;
    @(negedge tck);
    op_status();

    // Burst write crossing a byte boundary
    op_addr(16'h00FE);
    op_write(8'hA5);
    op_write(8'h5A);
    op_write(8'h3C);

    // Wrap at all-ones
    op_addr(16'hFFFF);
    op_write(8'h11);
    op_addr(16'h0000);

    // Prefetched reads
    op_addr(16'h0011); op_write(8'h88);
    op_addr(16'h0010); op_write(8'h77);
    op_addr(16'h0010);
    op_read();
    op_read();

    // Cycle-exact write sequence
    op_addr(16'h0020);
    dr_scan(2'd2, 16'h003C, DW, o);
    chk("t1_we", bus.mem_we, 1'b1);
    chk("t1_addr", bus.mem_addr, a_m);
    chk("t1_wdata", bus.mem_wdata, 8'h3C);
    chk("t1_re", bus.mem_re, 1'b0);
    @(negedge tck);
    chk("t2_we", bus.mem_we, 1'b0);
    chk("t2_re", bus.mem_re, 1'b0);
    @(negedge tck);
    chk("t3_re", bus.mem_re, 1'b1);
    chk("t3_addr", bus.mem_addr, a_m + STEP);
    @(negedge tck);
    chk("t4_re", bus.mem_re, 1'b0);
    mm[a_m] = 8'h3C;
    a_m = a_m + STEP;
    rbuf_m = mm[a_m];
    settle();

    // Overrun: second update one cycle after a WRITE update
    op_addr(16'h0030);
    n = wlog.size();
    dr_scan(2'd2, 16'h005E, DW, o);
    bus.v_udr = 1'b1;
    @(negedge tck);
    bus.v_udr = 1'b0;
    settle();
    chk("ovr_one_write", wlog.size(), n + 1);
    chk("ovr_entry", wlog[$], {a_m, 8'h5E});
    mm[a_m] = 8'h5E;
    a_m = a_m + STEP;
    rbuf_m = mm[a_m];
    ovr_m = 1'b1;
    op_status();
    op_status();

    // Stale: READ capture while the ADDR prefetch is still running
    dr_scan(2'd1, 16'h0010, AW, o);
    chk("stale_addr_capture", o, a_m);
    a_m = 16'h0010;
    rbuf_m = mm[a_m];
    bus.ir_in = 2'd3;
    bus.v_cdr = 1'b1;
    @(negedge tck);
    bus.v_cdr = 1'b0;
    settle();
    stl_m = 1'b1;
    op_status();
    op_read();

    // Same-address repeated writes (distinct addresses when auto-increment is on)
    op_addr(16'h0040);
    op_write(8'h01);
    op_write(8'h02);
    op_write(8'h03);

    // Reset in the middle of WR
    op_addr(16'h0050);
    n = wlog.size();
    dr_scan(2'd2, 16'h0099, DW, o);
    chk("pre_rst_we", bus.mem_we, 1'b1);
    #2 aclr = 1'b1;
    #1;
    chk("mid_rst_we", bus.mem_we, 1'b0);
    chk("mid_rst_addr", bus.mem_addr, 16'h0);
    chk("mid_rst_wdata", bus.mem_wdata, 8'h0);
    chk("mid_rst_tdo", bus.tdo, 1'b0);
    @(negedge tck);
    aclr = 1'b0;
    settle();
    chk("mid_rst_no_write", wlog.size(), n);
    a_m = '0; rbuf_m = '0; ovr_m = 1'b0; stl_m = 1'b0;
    op_status();
    op_read();

    // Randomized operation mix near both ends of the address space
    for (int t = 0; t < 80; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) op_addr($urandom_range(0, 1) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                               : 16'($urandom_range(0, 31)));
      else if (r < 6) op_write(8'($urandom));
      else if (r < 9) op_read();
      else op_status();
    end

    for (int i = 0; i < 32; i++) chk("final_lo", sram[i], mm[i]);
    for (int i = 16'hFFF0; i <= 16'hFFFF; i++) chk("final_hi", sram[i], mm[i]);
    for (int i = 16'h00FE; i <= 16'h0100; i++) chk("final_burst", sram[i], mm[i]);
    chk("final_0040", sram[16'h0040], mm[16'h0040]);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/vjtag_mem_bridge.md
# vjtag_mem_bridge

Parametrised virtual-JTAG to synchronous-memory access engine, the successor to the fixed 8-bit/16-bit JTAG-to-SRAM path. Decodes a small instruction set from the virtual JTAG IR and translates DR scans into single-cycle memory writes and prefetched reads. Supports address auto-increment for burst transfers and a sticky status register for overrun detection. Sits between the virtual JTAG hub signals and one SRAM port, entirely in the `tck` domain.

## Interface

Parameters:

- `ADDR_W`, 16, memory address width (2..32).
- `DATA_W`, 8, memory data width (1..64).
- `RD_LATENCY`, 1, `mem_re` to `mem_rdata` valid, in cycles (1..4).

Ports:

- `tck` input 1: the only clock; all logic on the rising edge.
- `aclr` input 1: asynchronous, active-high reset.
- `ir_in` input 2: instruction.
  - 0 = STATUS
  - 1 = ADDR
  - 2 = WRITE
  - 3 = READ
- `v_cdr` input 1: Capture-DR strobe.
- `v_sdr` input 1: Shift-DR strobe.
- `v_udr` input 1: Update-DR strobe.
- `tdi` input 1: serial data in.
- `tdo` output 1: serial data out, equal to `sr[0]`.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output DATA_W: write data.
- `mem_we` output 1: write strobe, one cycle.
- `mem_re` output 1: read strobe, one cycle.
- `mem_rdata` input DATA_W: read data, valid RD_LATENCY cycles after `mem_re`.

## Operation

Shift register `sr`:

- Width is max(ADDR_W, DATA_W, 8). LSB-first.
- The active DR length L depends on `ir_in`:
  - STATUS: L = 8.
  - ADDR: L = ADDR_W.
  - WRITE or READ: L = DATA_W.
- `v_sdr`: `sr[L-1]` <= `tdi`; `sr[L-2:0]` <= `sr[L-1:1]`. Bits at L and above are held at 0.

Capture (`v_cdr`):

- STATUS loads `{5'b0, stale, overrun, busy}`.
- ADDR loads `addr`.
- READ loads `rbuf`. If `busy` is 1 at this capture, `stale` is set.
- WRITE loads 0.

Update (`v_udr`):

- ADDR: `addr` <= `sr[ADDR_W-1:0]`; the FSM goes to PREFETCH.
- WRITE: `wreg` <= `sr[DATA_W-1:0]`; the FSM goes to WR.
- READ: the FSM goes to INC (advance the address), then PREFETCH.
- STATUS: clears `overrun` and `stale`.
- Any `v_udr` while the FSM is not IDLE is ignored, except the STATUS clear. The ignored update sets `overrun`.

FSM states:

- IDLE: waiting for an update.
- WR: `mem_we`=1, `mem_addr`=`addr`, `mem_wdata`=`wreg`. Next state INC.
- INC: `addr` <= `addr`+1, modulo 2^ADDR_W; all-ones wraps to 0. Next state PREFETCH.
- PREFETCH: `mem_re`=1, `mem_addr`=`addr`. Next state WAIT.
- WAIT: counts RD_LATENCY cycles. On the final cycle `rbuf` <= `mem_rdata`, then next state IDLE.

Other rules:

- `busy` = (state != IDLE).
- `mem_addr` always drives `addr`.
- `mem_wdata` always drives `wreg`.
- Simultaneous strobes: `v_udr` has priority over `v_cdr`, which has priority over `v_sdr`. The lower-priority strobes are ignored in that cycle.

## Timing

- Reset (`aclr`=1): all zero, immediately and asynchronously:
  - registers: `sr`, `addr`, `wreg`, `rbuf`, `overrun`, `stale`
  - state: IDLE
  - outputs: `tdo`, `mem_we`, `mem_re`, `mem_addr`, `mem_wdata`
- A reset in the middle of an operation abandons it. No strobe is issued after `aclr` rises.
- WRITE update at cycle t:
  - `mem_we` is high at t+1.
  - `addr` increments at t+2.
  - `mem_re` is high at t+3.
  - `rbuf` is valid at t+3+RD_LATENCY; `busy` falls in that cycle.
- ADDR update at t: `mem_re` at t+1; `rbuf` and idle at t+1+RD_LATENCY.
- READ update at t: `addr`+1 at t+1; `mem_re` at t+2; idle at t+2+RD_LATENCY.
- `tdo` is registered and changes only on `v_cdr`/`v_sdr` edges.

## Configuration

- `VJTAG_MEM_AUTOINC_EN` defined: INC increments `addr` as described above.
- `VJTAG_MEM_AUTOINC_EN` undefined:
  - INC holds `addr` unchanged.
  - WRITE and READ repeatedly target the same address.
  - Latencies are unchanged; INC still takes one cycle.

## Test plan

- Reset: assert `aclr` mid-WR. Required: `mem_we`=0 and `addr`=0 immediately; state IDLE; STATUS scan reads 0x00.
- Burst write: ADDR scan 0x00FE, then WRITE scans 0xA5, 0x5A, 0x3C with AUTOINC. Required: `mem_we` pulses at addresses 0x00FE, 0x00FF, 0x0100 with those data values.
- Wrap: ADDR 0xFFFF, one WRITE 0x11. Required: write at 0xFFFF; `addr` becomes 0x0000; prefetch `mem_re` at 0x0000.
- Prefetched read: memory holds 0x77 at 0x10 and 0x88 at 0x11. ADDR 0x0010, then two READ scans with RD_LATENCY=2. Required: the scans shift out 0x77 then 0x88.
- Overrun/stale: issue a WRITE update, then a second update 1 cycle later. Required: the second update is ignored. The next STATUS scan reads 0x02 (overrun set, busy clear); after that scan's update a further STATUS scan reads 0x00.
- Without `VJTAG_MEM_AUTOINC_EN`: ADDR 0x0040, three WRITE scans. Required: all three `mem_we` pulses at 0x0040; the final memory value equals the last data.
